// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-lane data RAM.
// Size encodings, FSM state type and the lane strobe helper.
package ram_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  // Strobe for up to 8 lanes; callers truncate to their lane count.
  function automatic logic [7:0] lane_mask(
    input logic [1:0] size,
    input logic [2:0] off
  );
    logic [7:0] m;
    m = 8'h00;
    unique case (size_e'(size))
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0f;
      default: m = 8'hff;
    endcase
    return m << off;
  endfunction

endpackage

// File: rtl/ram_bytelane_if.sv
// Load/store request bus between the LSU and the byte-lane RAM.
// master drives requests, slave returns load data and status.
interface ram_bytelane_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic              ce;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic              sign_ext;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              err;
  logic              busy;

  modport master (
    output ce, we, addr, size, sign_ext, data_in,
    input  data_out, valid, err, busy
  );

  modport slave (
    input  ce, we, addr, size, sign_ext, data_in,
    output data_out, valid, err, busy
  );
endinterface

// File: rtl/ram_lane_align.sv
// Lane steering for sub-word stores and loads.
// Stores shift data up to the lane offset; loads shift down and extend.
module ram_lane_align
  import ram_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NL = DATA_W / 8,
  localparam int OB = $clog2(NL)
) (
  input  logic [1:0]        size,
  input  logic [OB-1:0]     off,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] wdata,
  output logic [NL-1:0]     wstrb,
  output logic [DATA_W-1:0] rdata
);
  logic [OB+2:0]     sh_amt;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] mask;
  logic              msb;

  assign sh_amt = {off, 3'b000};
  assign wdata  = data_in << sh_amt;
  assign wstrb  = NL'(lane_mask(size, 3'(off)));
  assign sh     = raw >> sh_amt;

  always_comb begin
    mask = '1;
    msb  = 1'b0;
    unique case (size_e'(size))
      SZ_B: begin
        mask = DATA_W'(8'hff);
        msb  = sh[7];
      end
      SZ_H: begin
        mask = DATA_W'(16'hffff);
        msb  = sh[15];
      end
      SZ_W: begin
        mask = DATA_W'(32'hffff_ffff);
        msb  = sh[31];
      end
      default: begin
        mask = '1;
        msb  = sh[DATA_W-1];
      end
    endcase
  end

  assign rdata = (sh & mask) |
                 ((sign_ext && msb) ? ~mask : '0);
endmodule

// File: rtl/ram_bytelane.sv
// Byte-addressed data RAM with sub-word access and a one-cycle read.
// Zero-fills the array after reset before accepting requests.
module ram_bytelane
  import ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024
) (
  input logic           clk,
  input logic           rst,
  ram_bytelane_if.slave bus
);
  localparam int NL = DATA_W / 8;
  localparam int OB = $clog2(NL);
  localparam int IW = ADDR_W - OB;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state;
  logic [AW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [AW-1:0]     widx;
  logic [OB-1:0]     off;
  logic [2:0]        amask;
  logic              bad_size;
  logic              misalign;
  logic              oor;
  logic              bad;
  logic              live;
  logic              take;
  logic [NL-1:0]     wstrb;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] raw;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] dout;
  logic              vld;
  logic              er;

  assign idx  = bus.addr[ADDR_W-1:OB];
  assign off  = bus.addr[OB-1:0];
  assign widx = idx[AW-1:0];

  always_comb begin
    amask = 3'd0;
    unique case (size_e'(bus.size))
      SZ_B:    amask = 3'd0;
      SZ_H:    amask = 3'd1;
      SZ_W:    amask = 3'd3;
      default: amask = 3'd7;
    endcase
  end

  assign bad_size = int'(bus.size) > OB;
  assign misalign = |(3'(off) & amask);
  assign oor      = {1'b0, idx} >= (IW+1)'(DEPTH);
  assign bad      = bad_size | misalign | oor;
  assign live     = (state == ST_IDLE) && bus.ce;
  assign take     = live && !bad;
  assign raw      = mem[widx];

  ram_lane_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .size    (bus.size),
    .off     (off),
    .sign_ext(bus.sign_ext),
    .data_in (bus.data_in),
    .raw     (raw),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .rdata   (rdata)
  );

  // Array has no reset; the sweep owns the write port while in INIT.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[cnt] <= '0;
    end else if (take && bus.we) begin
      for (int i = 0; i < NL; i++) begin
        if (wstrb[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
      dout  <= '0;
      vld   <= 1'b0;
      er    <= 1'b0;
    end else begin
      dout <= '0;
      vld  <= 1'b0;
      er   <= 1'b0;
      unique case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= ST_IDLE;
        end
        default: begin
          if (live && bad) begin
            er <= 1'b1;
          end else if (take && !bus.we) begin
            vld  <= 1'b1;
            dout <= rdata;
          end
        end
      endcase
    end
  end

  assign bus.data_out = dout;
  assign bus.valid    = vld;
  assign bus.err      = er;
  assign bus.busy     = (state == ST_INIT);
endmodule

// File: tb/tb_ram_bytelane.sv
// Directed bench for ram_bytelane with an expected-result queue.
// Each request pushes its expected outcome; the next edge pops and checks it.
module tb_ram_bytelane;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 1024;

  typedef struct {
    string       tag;
    logic        v;
    logic        e;
    logic [31:0] d;
  } exp_t;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  exp_t sb[$];

  ram_bytelane_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram_bytelane #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t x;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    x = sb.pop_front();
    chk({x.tag, ".valid"}, 32'(bus.valid), 32'(x.v));
    chk({x.tag, ".err"}, 32'(bus.err), 32'(x.e));
    chk({x.tag, ".data"}, bus.data_out, x.d);
  endtask

  task automatic step(input string tag, input logic c, input logic w,
                      input logic [15:0] a, input logic [1:0] s,
                      input logic sx, input logic [31:0] din,
                      input logic ev, input logic ee,
                      input logic [31:0] ed);
    exp_t x;
    @(negedge clk);
    bus.ce       = c;
    bus.we       = w;
    bus.addr     = a;
    bus.size     = s;
    bus.sign_ext = sx;
    bus.data_in  = din;
    x.tag = tag;
    x.v   = ev;
    x.e   = ee;
    x.d   = ed;
    sb.push_back(x);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic wait_sweep(output int n, output logic saw_v);
    n     = 0;
    saw_v = 1'b0;
    while (n < 3 * DEPTH) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.valid || bus.err) saw_v = 1'b1;
      if (!bus.busy) break;
    end
  endtask

  initial begin
    int   n;
    logic sv;
    n_assert = 0;
    n_fail   = 0;
    rst          = 1'b1;
    bus.ce       = 1'b1;
    bus.we       = 1'b0;
    bus.addr     = 16'h0;
    bus.size     = 2'b10;
    bus.sign_ext = 1'b0;
    bus.data_in  = 32'h0;
    #2;
    chk("rst.busy", 32'(bus.busy), 32'd1);
    chk("rst.valid", 32'(bus.valid), 32'd0);
    chk("rst.err", 32'(bus.err), 32'd0);
    chk("rst.data", bus.data_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_sweep(n, sv);
    chk("sweep.len", 32'(n), 32'(DEPTH));
    chk("sweep.quiet", 32'(sv), 32'd0);
    step("ld0", 1, 0, 16'h0, 2'b10, 0, 0, 1, 0, 32'h0);

    step("st_w0", 1, 1, 16'h0, 2'b10, 0, 32'hdeadbeef, 0, 0, 0);
    step("ld_b3s", 1, 0, 16'h3, 2'b00, 1, 0, 1, 0, 32'hffffffde);
    step("ld_h0z", 1, 0, 16'h0, 2'b01, 0, 0, 1, 0, 32'h0000beef);
    step("ld_h2s", 1, 0, 16'h2, 2'b01, 1, 0, 1, 0, 32'hffffdead);
    step("ld_b1z", 1, 0, 16'h1, 2'b00, 0, 0, 1, 0, 32'h000000be);
    step("idle", 0, 0, 16'h0, 2'b10, 0, 0, 0, 0, 0);

    step("st_w4", 1, 1, 16'h4, 2'b10, 0, 32'h12345678, 0, 0, 0);
    step("st_b5", 1, 1, 16'h5, 2'b00, 0, 32'hffffff55, 0, 0, 0);
    step("ld_w4", 1, 0, 16'h4, 2'b10, 0, 0, 1, 0, 32'h12345578);
    step("st_h6", 1, 1, 16'h6, 2'b01, 0, 32'h0000abcd, 0, 0, 0);
    step("ld_w4b", 1, 0, 16'h4, 2'b10, 0, 0, 1, 0, 32'habcd5578);

    step("ld_h1", 1, 0, 16'h1, 2'b01, 0, 0, 0, 1, 0);
    step("st_w6", 1, 1, 16'h6, 2'b10, 0, 32'h99999999, 0, 1, 0);
    step("ld_w4c", 1, 0, 16'h4, 2'b10, 0, 0, 1, 0, 32'habcd5578);
    step("ld_oor", 1, 0, 16'h1000, 2'b10, 0, 0, 0, 1, 0);
    step("st_oor", 1, 1, 16'h1000, 2'b00, 0, 32'h11, 0, 1, 0);
    step("ld_d", 1, 0, 16'h0, 2'b11, 0, 0, 0, 1, 0);
    step("ld_top", 1, 0, 16'h0ffc, 2'b10, 0, 0, 1, 0, 32'h0);

    step("st_w8", 1, 1, 16'h8, 2'b10, 0, 32'haaaaaaaa, 0, 0, 0);
    step("st_wc", 1, 1, 16'hc, 2'b10, 0, 32'h55555555, 0, 0, 0);
    step("ld_8", 1, 0, 16'h8, 2'b10, 0, 0, 1, 0, 32'haaaaaaaa);
    step("ld_c", 1, 0, 16'hc, 2'b10, 0, 0, 1, 0, 32'h55555555);
    step("idle2", 0, 0, 16'h8, 2'b10, 0, 0, 0, 0, 0);

    @(negedge clk);
    bus.ce = 1'b0;
    rst    = 1'b1;
    #1;
    chk("rst2.busy", 32'(bus.busy), 32'd1);
    chk("rst2.data", bus.data_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("mid.busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.ce = 1'b1;
    rst    = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_sweep(n, sv);
    chk("sweep2.len", 32'(n), 32'(DEPTH));
    chk("sweep2.quiet", 32'(sv), 32'd0);
    step("ld_8z", 1, 0, 16'h8, 2'b10, 0, 0, 1, 0, 32'h0);
    step("ld_4z", 1, 0, 16'h4, 2'b10, 0, 0, 1, 0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
